membank_burst: RTL
==================

MEMBANK_BURST -- requirements
Module: membank_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, words in bank (power of 2).
REQ-003 SHALL have parameter ADDR_W, default 28, word-address port width.
REQ-004 SHALL have parameter BEATS, default 4, words per cache line (power of 2, at most DEPTH).
REQ-005 SHALL have parameter LATENCY, default 2, wait cycles between request accept and first beat (0 legal).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 SHALL have req_valid in 1, req_ready out 1, req_write in 1 (1=write line), req_addr in ADDR_W (word address).
REQ-009 SHALL have wr_valid in 1, wr_ready out 1, wr_data in DATA_W, wr_be in DATA_W/8 (byte enables).
REQ-010 SHALL have rd_valid out 1, rd_data out DATA_W, rd_last out 1 (final beat of a read).
REQ-011 SHALL have init_done out 1 (clear sweep complete) and busy out 1 (FSM not in IDLE).

Function
REQ-012 SHALL use FSM states INIT, IDLE, WAIT, RD_BURST, WR_BURST; INIT is entered from reset.
REQ-013 INIT SHALL write zero to one word per cycle, index 0 to DEPTH-1, then go to IDLE and set init_done, exactly DEPTH cycles after rst deasserts.
REQ-014 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-015 Word index SHALL be req_addr mod DEPTH; higher address bits are ignored and alias.
REQ-016 Line base SHALL be the index with its low log2(BEATS) bits cleared; the start beat SHALL be those low bits (critical word first).
REQ-017 Beat k SHALL address line base + ((start + k) mod BEATS); bursts wrap within the line and never cross it.
REQ-018 After accept, the FSM SHALL spend LATENCY cycles in WAIT (skipped when LATENCY=0), then enter RD_BURST or WR_BURST.
REQ-019 Read: rd_valid SHALL be 1 for exactly BEATS consecutive cycles, first at accept cycle + LATENCY + 1; there is no backpressure.
REQ-020 rd_last SHALL be 1 with the final rd_valid beat only; rd_data SHALL be 0 whenever rd_valid is 0.
REQ-021 Write: wr_ready SHALL be 1 throughout WR_BURST; each cycle with wr_valid and wr_ready writes one beat.
REQ-022 Each write beat SHALL update only the bytes whose wr_be bit is 1.
REQ-023 When wr_valid is 0, the write beat counter SHALL hold; the FSM returns to IDLE the cycle after the BEATS-th accepted beat.
REQ-024 A write SHALL be visible to any request accepted after it completes; a read returns the contents of each word at the cycle that beat is sent.
REQ-025 req_write and req_addr SHALL be captured at accept; changes during a burst SHALL have no effect.
REQ-026 busy SHALL equal (state != IDLE).

Reset
REQ-027 While rst is 1, outputs SHALL be: req_ready 0, wr_ready 0, rd_valid 0, rd_last 0, rd_data 0, init_done 0, busy 1.
REQ-028 rst asserted mid-burst SHALL abort the burst at once; no further array writes occur, and INIT restarts when rst deasserts.
REQ-029 Array contents SHALL NOT be cleared by rst itself; only the INIT sweep clears them.

Structure
REQ-030 Package membank_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-031 SHALL instantiate one sub-module, membank_array: DEPTH x DATA_W storage, synchronous byte-enabled write, combinational read.
REQ-032 Beat and latency counters SHALL be sized by $clog2 of BEATS and LATENCY+1.

Verification (defaults)
REQ-033 Release rst after 3 cycles -> init_done rises exactly 256 cycles later; read of addr 0x0 returns 0,0,0,0.
REQ-034 Write addr 0x10, data A0,A1,A2,A3 with be=F, then read addr 0x12 -> beats A2,A3,A0,A1; rd_valid first at accept+3; rd_last on the 4th beat.
REQ-035 Word 0x20 is 0; write beat 0xFFFFFFFF with be=4'b0101 -> read gives 0x00FF00FF.
REQ-036 Write at addr 0x110, then read 0x10 -> identical data (aliasing).
REQ-037 Hold wr_valid low for 3 cycles between beats 1 and 2 -> wr_ready stays 1 and exactly 4 beats are written.
REQ-038 Assert rst after 2 write beats -> no further writes; after re-init, a line read returns zeros.

Source files
------------

// File: rtl/membank_pkg.sv
// Shared definitions for the burst memory bank: FSM state encoding and
// default parameter values used by the top level and the bench.
package membank_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_BEATS   = 4;
  localparam int DEF_LATENCY = 2;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST
  } state_e;

endpackage

// File: rtl/membank_array.sv
// DEPTH x DATA_W storage with a synchronous byte-enabled write port and a
// combinational read port. Contents are never reset; the owner clears them.
module membank_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wbe_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
        if (wbe_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/membank_burst.sv
// Line-oriented memory bank: clears itself after reset, then serves
// critical-word-first wrapping read and write bursts of BEATS words.
module membank_burst
  import membank_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                init_done,
  output logic                busy
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [IDX_W-1:0]  OFF_MASK  = IDX_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_e             state_q;
  logic [IDX_W-1:0]   init_idx_q;
  logic [IDX_W-1:0]   line_idx_q;
  logic [BEAT_W-1:0]  beat_q;
  logic [LAT_W-1:0]   lat_q;
  logic               write_q;
  logic               init_done_q;

  logic [IDX_W-1:0]   beat_off;
  logic [IDX_W-1:0]   beat_idx;
  logic               arr_we;
  logic [IDX_W-1:0]   arr_waddr;
  logic [DATA_W-1:0]  arr_wdata;
  logic [DATA_W/8-1:0] arr_wbe;
  logic [DATA_W-1:0]  arr_rdata;
  logic               unused_addr_hi;

  // Upper address bits above the bank index alias and are deliberately dropped.
  assign unused_addr_hi = ^req_addr;

  // Beat address: keep the line base, wrap the offset within the line.
  always_comb begin
    beat_off = (line_idx_q + IDX_W'(beat_q)) & OFF_MASK;
    beat_idx = (line_idx_q & ~OFF_MASK) | beat_off;
  end

  // Control FSM: init sweep, request capture, latency wait and burst counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      init_idx_q  <= '0;
      init_done_q <= 1'b0;
      line_idx_q  <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      write_q     <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          if (init_idx_q == IDX_LAST) begin
            state_q     <= IDLE;
            init_done_q <= 1'b1;
          end
        end
        IDLE: begin
          if (req_valid) begin
            line_idx_q <= req_addr[IDX_W-1:0];
            write_q    <= req_write;
            beat_q     <= '0;
            lat_q      <= '0;
            if (LATENCY == 0) begin
              state_q <= req_write ? WR_BURST : RD_BURST;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q <= write_q ? WR_BURST : RD_BURST;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        RD_BURST: begin
          if (beat_q == BEAT_LAST) begin
            state_q <= IDLE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        WR_BURST: begin
          if (wr_valid) begin
            if (beat_q == BEAT_LAST) begin
              state_q <= IDLE;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Array port steering; writes are suppressed while rst is held so a
  // mid-burst reset cannot land a partial beat.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = beat_idx;
    arr_wdata = wr_data;
    arr_wbe   = wr_be;
    if (!rst) begin
      if (state_q == INIT) begin
        arr_we    = 1'b1;
        arr_waddr = init_idx_q;
        arr_wdata = '0;
        arr_wbe   = '1;
      end else if (state_q == WR_BURST) begin
        arr_we = wr_valid;
      end
    end
  end

  membank_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .wbe_i   (arr_wbe),
    .raddr_i (beat_idx),
    .rdata_o (arr_rdata)
  );

  // Handshake and status outputs, forced to their reset values while rst is high.
  always_comb begin
    req_ready = !rst && (state_q == IDLE);
    wr_ready  = !rst && (state_q == WR_BURST);
    rd_valid  = !rst && (state_q == RD_BURST);
    rd_last   = rd_valid && (beat_q == BEAT_LAST);
    rd_data   = rd_valid ? arr_rdata : '0;
    init_done = !rst && init_done_q;
    busy      = rst || (state_q != IDLE);
  end

endmodule
